// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for RV64 DIV/DIVU/REM/REMU with valid/ready handshake and flush.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and |a|<|b| complete directly from IDLE.
module div_seq #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic [1:0]      div_func_i,
  input  logic            flush_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            busy_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic            is_rem_q;
  logic            q_neg_q, r_neg_q;
  logic            div0_q, ovf_q;
  logic [XLEN-1:0] a_q, dvs_q, quo_q, rem_q, res_q;
  logic [CNT_W-1:0] cnt_q;

  logic            accept;
  logic            is_signed, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div0_in, ovf_in;
  logic            early_go;
  logic [XLEN-1:0] early_res;
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] rem_step, quo_step, q_fix, r_fix, calc_res;

  assign req_ready_o = (state == IDLE) && !flush_i;
  assign res_valid_o = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign res_o       = res_q;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    is_signed = ~div_func_i[0];
    a_neg     = is_signed & opr_a_i[XLEN-1];
    b_neg     = is_signed & opr_b_i[XLEN-1];
    abs_a     = a_neg ? -opr_a_i : opr_a_i;
    abs_b     = b_neg ? -opr_b_i : opr_b_i;
    div0_in   = (opr_b_i == '0);
    ovf_in    = is_signed && (opr_a_i == MIN_NEG) && (opr_b_i == '1);
  end

`ifdef DIV_EARLY_OUT_EN
  always_comb begin
    early_go  = div0_in || ovf_in || (abs_a < abs_b);
    early_res = div_func_i[1] ? opr_a_i : '0;
    if (div0_in) begin
      early_res = div_func_i[1] ? opr_a_i : '1;
    end else if (ovf_in) begin
      early_res = div_func_i[1] ? '0 : opr_a_i;
    end
  end
`else
  assign early_go  = 1'b0;
  assign early_res = '0;
`endif

  // One restoring step; rem_sh carries an extra bit so the shifted remainder cannot overflow.
  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    ge       = (rem_sh >= {1'b0, dvs_q});
    rem_step = ge ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], ge};
    q_fix    = q_neg_q ? -quo_step : quo_step;
    r_fix    = r_neg_q ? -rem_step : rem_step;
    calc_res = is_rem_q ? r_fix : q_fix;
    if (div0_q) begin
      calc_res = is_rem_q ? a_q : '1;
    end else if (ovf_q) begin
      calc_res = is_rem_q ? '0 : a_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) state_nxt = early_go ? DONE : CALC;
        CALC: if (cnt_q == '0) state_nxt = DONE;
        DONE: if (res_ready_i) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_q      <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      is_rem_q <= div_func_i[1];
      q_neg_q  <= a_neg ^ b_neg;
      r_neg_q  <= a_neg;
      div0_q   <= div0_in;
      ovf_q    <= ovf_in;
      a_q      <= opr_a_i;
      dvs_q    <= abs_b;
      quo_q    <= abs_a;
      rem_q    <= '0;
      cnt_q    <= CNT_W'(XLEN-1);
      if (early_go) res_q <= early_res;
    end else if (state == CALC && !flush_i) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      if (cnt_q == '0) res_q <= calc_res;
      else             cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed RV64 divide cases, flush, backpressure, reset and random ops.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] opr_a_i;
  logic [63:0] opr_b_i;
  logic [1:0]  div_func_i;
  logic        flush_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [63:0] res_o;
  logic        busy_o;

  int tests_run = 0;
  int fails     = 0;

  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

  div_seq #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .opr_a_i(opr_a_i), .opr_b_i(opr_b_i), .div_func_i(div_func_i),
    .flush_i(flush_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // RISC-V M-extension semantics using native SV arithmetic.
  function automatic logic [63:0] ref_div(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    sa = a;
    sb = b;
    if (b == 64'd0) return f[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    if (!f[0] && a == MIN_NEG && b == 64'hFFFF_FFFF_FFFF_FFFF) return f[1] ? 64'd0 : a;
    case (f)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [63:0] ma, mb;
    ma = (!f[0] && a[63]) ? (64'd0 - a) : a;
    mb = (!f[0] && b[63]) ? (64'd0 - b) : b;
    if (b == 64'd0 || (!f[0] && a == MIN_NEG && b == 64'hFFFF_FFFF_FFFF_FFFF) || ma < mb) return 1;
`endif
    return 65;
  endfunction

  task automatic start_op(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    div_func_i  = f;
    opr_a_i     = a;
    opr_b_i     = b;
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (!res_valid_o && lat < 200) begin
      if (!busy_o) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!busy_o) busy_ok = 1'b0;
  endtask

  task automatic pop();
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat, output logic busy_ok);
    start_op(f, a, b);
    wait_valid(lat, busy_ok);
    res = res_o;
    pop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid_i = 1'b0; res_ready_i = 1'b0; flush_i = 1'b0;
    opr_a_i = '0; opr_b_i = '0; div_func_i = 2'b00;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready_o, res_valid_o, busy_o} !== 3'b100 || res_o !== 64'd0) begin
      fails++;
      $display("FAIL reset: ready/valid/busy=%b res=%h, required 100 res=0", {req_ready_o, res_valid_o, busy_o}, res_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]  fv [12] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b11, 2'b00, 2'b10};
    logic [63:0] av [12] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd100, 64'd5,
                             64'hFFFF_FFFF_FFFF_FFFB, 64'd5, MIN_NEG, MIN_NEG, 64'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9};
    logic [63:0] bv [12] = '{64'd2, 64'd2, 64'd7, 64'd7, 64'd0, 64'd0, 64'd0,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10,
                             64'hFFFF_FFFF_FFFF_FFFE, 64'd3};
    logic [63:0] ev [12] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd14, 64'd2,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, MIN_NEG, 64'd0,
                             64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] res;
    int lat;
    logic busy_ok;
    for (int i = 0; i < 12; i++) begin
      do_op(fv[i], av[i], bv[i], res, lat, busy_ok);
      tests_run++;
      if (res !== ev[i] || res !== ref_div(fv[i], av[i], bv[i])) begin
        fails++;
        $display("FAIL directed[%0d] result: got %h, required %h", i, res, ev[i]);
      end
      tests_run++;
      if (lat !== ref_lat(fv[i], av[i], bv[i])) begin
        fails++;
        $display("FAIL directed[%0d] latency: got %0d, required %0d", i, lat, ref_lat(fv[i], av[i], bv[i]));
      end
      tests_run++;
      if (!busy_ok || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
        fails++;
        $display("FAIL directed[%0d] busy/ready: busy_ok=%b ready=%b busy=%b, required 1 1 0", i, busy_ok, req_ready_o, busy_o);
      end
    end
  endtask

  task automatic test_flush();
    logic seen_valid = 1'b0;
    logic [63:0] res;
    int lat;
    logic busy_ok;
    start_op(2'b01, 64'hFFFF_0000_1234_5678, 64'd13);
    repeat (19) @(negedge clk);
    flush_i = 1'b1;
    req_valid_i = 1'b1;
    #1;
    tests_run++;
    if (req_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL flush ready during flush: got %b, required 0", req_ready_o);
    end
    @(negedge clk);
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    #1;
    tests_run++;
    if ({req_ready_o, busy_o, res_valid_o} !== 3'b100) begin
      fails++;
      $display("FAIL flush idle: ready/busy/valid=%b, required 100", {req_ready_o, busy_o, res_valid_o});
    end
    repeat (70) begin
      @(negedge clk);
      if (res_valid_o) seen_valid = 1'b1;
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush no result: res_valid seen=%b, required 0", seen_valid);
    end
    do_op(2'b01, 64'd9, 64'd3, res, lat, busy_ok);
    tests_run++;
    if (res !== 64'd3) begin
      fails++;
      $display("FAIL flush next op: got %h, required 3", res);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    int lat;
    logic busy_ok;
    start_op(2'b11, 64'd100, 64'd7);
    wait_valid(lat, busy_ok);
    held = res_o;
    tests_run++;
    if (held !== 64'd2) begin
      fails++;
      $display("FAIL backpressure result: got %h, required 2", held);
    end
    div_func_i = 2'b01; opr_a_i = 64'd50; opr_b_i = 64'd5;
    req_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests_run++;
      if (res_o !== held || req_ready_o !== 1'b0 || res_valid_o !== 1'b1) begin
        fails++;
        $display("FAIL backpressure hold[%0d]: res=%h ready=%b valid=%b, required %h 0 1", i, res_o, req_ready_o, res_valid_o, held);
      end
    end
    req_valid_i = 1'b0;
    pop();
    tests_run++;
    if ({req_ready_o, res_valid_o, busy_o} !== 3'b100 || res_o !== held) begin
      fails++;
      $display("FAIL backpressure pop: ready/valid/busy=%b res=%h, required 100 res=%h", {req_ready_o, res_valid_o, busy_o}, res_o, held);
    end
  endtask

  task automatic test_reset_midcalc();
    logic [63:0] res;
    int lat;
    logic busy_ok;
    start_op(2'b00, 64'd123456789, 64'd1000);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({req_ready_o, res_valid_o, busy_o} !== 3'b100 || res_o !== 64'd0) begin
      fails++;
      $display("FAIL reset midcalc: ready/valid/busy=%b res=%h, required 100 res=0", {req_ready_o, res_valid_o, busy_o}, res_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b00, 64'd123456789, 64'd1000, res, lat, busy_ok);
    tests_run++;
    if (res !== 64'd123456) begin
      fails++;
      $display("FAIL after reset op: got %h, required %h", res, 64'd123456);
    end
  endtask

  task automatic test_random();
    logic [1:0]  f;
    logic [63:0] a, b, res;
    int lat;
    logic busy_ok;
    for (int i = 0; i < 40; i++) begin
      f = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = 64'd0;
        1: begin f[0] = 1'b0; a = MIN_NEG; b = 64'hFFFF_FFFF_FFFF_FFFF; end
        2: b = 64'($urandom_range(1, 1000));
        3: a = 64'($urandom_range(0, 1000));
        4: b = {32'd0, $urandom};
        default: ;
      endcase
      do_op(f, a, b, res, lat, busy_ok);
      tests_run++;
      if (res !== ref_div(f, a, b) || lat !== ref_lat(f, a, b)) begin
        fails++;
        $display("FAIL random[%0d] f=%b a=%h b=%h: got %h lat %0d, required %h lat %0d",
                 i, f, a, b, res, lat, ref_div(f, a, b), ref_lat(f, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_backpressure();
    test_reset_midcalc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
